// File: rtl/text_console_if.sv
// Keyboard-in / character-buffer-out bundle for the text console.
interface text_console_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic              new_key;
  logic [7:0]        ascii;
  logic [7:0]        attr_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              we;
  logic [RW-1:0]     top_row;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;
  logic              busy;
  logic              overflow;

  // keyboard/video side
  modport master (output new_key, ascii, attr_in,
                  input  mem_addr, mem_data, we, top_row, cur_col, cur_row, busy, overflow);
  // console side
  modport slave  (input  new_key, ascii, attr_in,
                  output mem_addr, mem_data, we, top_row, cur_col, cur_row, busy, overflow);
endinterface

// File: rtl/text_console.sv
// Scrolling text console: turns key codes into character-buffer writes,
// tracks the cursor, and scrolls by moving top_row instead of copying rows.
module text_console #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] DEF_ATTR = 8'h07
) (
  input  logic           sys_clk,
  input  logic           rst,
  text_console_if.slave  bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] S_CLR_ALL  = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;
  localparam logic [1:0] S_CLR_LINE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS*COLS - 1);
  localparam logic [ADDR_W-1:0] LINE_END  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((ROWS-1)*COLS);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
  localparam logic [15:0]       BLANK     = {DEF_ATTR, 8'h20};

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_base;   // physical row of the cursor times COLS
  logic [RW-1:0]     r_prow;   // physical row of the cursor
  logic [RW-1:0]     r_top, r_row;
  logic [CW-1:0]     r_col;
  logic [15:0]       r_data;
  logic              r_adv;    // WRITE advances the cursor afterwards (not for BS)
  logic              r_pend_vld, r_ovf;
  logic [7:0]        r_pend_ch, r_pend_attr;

  logic              w_acc, w_fwd, w_back, w_adv_n;
  logic [7:0]        w_ch, w_attr;
  logic [1:0]        w_state_n;
  logic [ADDR_W-1:0] w_cnt_n;
  logic [CW-1:0]     w_col_n;
  logic [15:0]       w_data_n;
  logic [CW:0]       w_tab;

  // pending slot has priority over a key arriving in the same cycle
  assign w_acc  = (r_state == S_IDLE) && (r_pend_vld || bus.new_key);
  assign w_ch   = r_pend_vld ? r_pend_ch   : bus.ascii;
  assign w_attr = r_pend_vld ? r_pend_attr : bus.attr_in;
  assign w_tab  = ({1'b0, r_col} | (CW+1)'(7)) + 1'b1;

  // next-state, column and row-step decisions
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_col_n   = r_col;
    w_data_n  = r_data;
    w_adv_n   = r_adv;
    w_fwd     = 1'b0;
    w_back    = 1'b0;
    case (r_state)
      S_CLR_ALL: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_cnt == LAST_CELL) begin w_state_n = S_IDLE; w_cnt_n = '0; end
      end
      S_CLR_LINE: begin
        w_cnt_n = r_cnt + 1'b1;
        if (r_cnt == LINE_END) begin w_state_n = S_IDLE; w_cnt_n = '0; end
      end
      S_WRITE: begin
        w_state_n = S_IDLE;
        if (r_adv) begin
          if (r_col == LAST_COL) begin w_col_n = '0; w_fwd = 1'b1; end
          else w_col_n = r_col + 1'b1;
        end
      end
      default: begin
        if (w_acc) begin
          if (w_ch >= 8'h20 && w_ch <= 8'h7E) begin
            w_state_n = S_WRITE; w_data_n = {w_attr, w_ch}; w_adv_n = 1'b1;
          end else if (w_ch == 8'h0D) begin
            w_col_n = '0; w_fwd = 1'b1;
          end else if (w_ch == 8'h08) begin
            if (r_col != '0) begin
              w_col_n = r_col - 1'b1;
              w_state_n = S_WRITE; w_data_n = BLANK; w_adv_n = 1'b0;
            end else if (r_row != '0) begin
              w_col_n = LAST_COL; w_back = 1'b1;
              w_state_n = S_WRITE; w_data_n = BLANK; w_adv_n = 1'b0;
            end
          end else if (w_ch == 8'h09) begin
            w_col_n = (w_tab > (CW+1)'(COLS-1)) ? LAST_COL : w_tab[CW-1:0];
          end
        end
      end
    endcase
    // stepping off the bottom row scrolls and blanks the new bottom line
    if (w_fwd && r_row == LAST_ROW) begin w_state_n = S_CLR_LINE; w_cnt_n = '0; end
  end

  // state, cursor and scroll registers; row base tracked incrementally
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= S_CLR_ALL;
      r_cnt   <= '0;
      r_base  <= '0;
      r_prow  <= '0;
      r_top   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_col   <= w_col_n;
      r_data  <= w_data_n;
      r_adv   <= w_adv_n;
      if (w_fwd) begin
        r_prow <= (r_prow == LAST_ROW) ? '0 : r_prow + 1'b1;
        r_base <= (r_prow == LAST_ROW) ? '0 : r_base + ROW_STEP;
        if (r_row == LAST_ROW) r_top <= (r_top == LAST_ROW) ? '0 : r_top + 1'b1;
        else                   r_row <= r_row + 1'b1;
      end else if (w_back) begin
        r_prow <= (r_prow == '0) ? LAST_ROW  : r_prow - 1'b1;
        r_base <= (r_prow == '0) ? LAST_BASE : r_base - ROW_STEP;
        r_row  <= r_row - 1'b1;
      end
    end
  end

  // one-entry pending slot; a key landing as the slot drains refills it
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_pend_vld  <= 1'b0;
      r_pend_ch   <= '0;
      r_pend_attr <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && r_pend_vld) r_pend_vld <= 1'b0;
      if (bus.new_key && !(r_state == S_IDLE && !r_pend_vld)) begin
        if (!r_pend_vld || r_state == S_IDLE) begin
          r_pend_vld  <= 1'b1;
          r_pend_ch   <= bus.ascii;
          r_pend_attr <= bus.attr_in;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // write port: clears walk r_cnt, character writes hit the cursor cell
  always_comb begin
    case (r_state)
      S_CLR_ALL:  bus.mem_addr = r_cnt;
      S_CLR_LINE: bus.mem_addr = r_base + r_cnt;
      default:    bus.mem_addr = r_base + ADDR_W'(r_col);
    endcase
    bus.mem_data = (r_state == S_WRITE) ? r_data : BLANK;
  end

  assign bus.we       = !rst && (r_state != S_IDLE);
  assign bus.busy     = rst || r_state == S_CLR_ALL || r_state == S_CLR_LINE;
  assign bus.top_row  = r_top;
  assign bus.cur_col  = r_col;
  assign bus.cur_row  = r_row;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: scenario tasks plus a cursor/buffer
// reference model that works in plain (row, col, top) arithmetic.
module tb_text_console;
  localparam int COLS = 80, ROWS = 30, ADDR_W = 12;
  localparam int CW = $clog2(COLS), RW = $clog2(ROWS);

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  text_console_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) bus();
  text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DEF_ATTR(8'h07))
    dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));

  always #5 sys_clk = ~sys_clk;

  int n_run = 0, n_fail = 0;

  // every buffer write seen, as {addr, data}
  logic [31:0] got_q[$];
  always @(negedge sys_clk)
    if (bus.we === 1'b1) got_q.push_back({16'(bus.mem_addr), bus.mem_data});

  // reference model
  int m_col, m_row, m_top, rd;
  logic [31:0] exp_q[$];
  logic [31:0] e, g;

  function automatic int phys(int r, int c);
    return ((m_top + r) % ROWS) * COLS + c;
  endfunction

  function automatic void m_row_adv();
    if (m_row < ROWS-1) m_row++;
    else begin
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < COLS; c++) exp_q.push_back({16'(phys(ROWS-1, c)), 16'h0720});
    end
  endfunction

  function automatic void model_key(logic [7:0] ch, logic [7:0] at);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back({16'(phys(m_row, m_col)), at, ch});
      if (m_col == COLS-1) begin m_col = 0; m_row_adv(); end
      else m_col++;
    end else if (ch == 8'h0D) begin
      m_col = 0; m_row_adv();
    end else if (ch == 8'h08) begin
      if (m_col > 0 || m_row > 0) begin
        if (m_col > 0) m_col--;
        else begin m_row--; m_col = COLS-1; end
        exp_q.push_back({16'(phys(m_row, m_col)), 16'h0720});
      end
    end else if (ch == 8'h09) begin
      m_col = (((m_col / 8) + 1) * 8 > COLS-1) ? COLS-1 : ((m_col / 8) + 1) * 8;
    end
  endfunction

  function automatic void model_reset();
    m_col = 0; m_row = 0; m_top = 0;
    exp_q.delete();
    for (int a = 0; a < ROWS*COLS; a++) exp_q.push_back({16'(a), 16'h0720});
  endfunction

  task automatic send_key(input logic [7:0] ch, input logic [7:0] at);
    @(posedge sys_clk); #1;
    bus.new_key = 1'b1; bus.ascii = ch; bus.attr_in = at;
    @(posedge sys_clk); #1;
    bus.new_key = 1'b0;
  endtask

  // wait for three consecutive cycles with neither busy nor we
  task automatic wait_quiet(input string tag);
    int q = 0, n = 0;
    while (q < 3 && n < 5000) begin
      @(negedge sys_clk); n++;
      if (!bus.busy && !bus.we) q++; else q = 0;
    end
    n_run++;
    if (q < 3) begin n_fail++; $display("FAIL %s_timeout cycles=%0d", tag, n); end
  endtask

  task automatic test_reset();
    int n = 0;
    bus.new_key = 1'b1; bus.ascii = 8'h5A; bus.attr_in = 8'h70;  // ignored during rst
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_run++;
    if ({bus.we, bus.busy, bus.overflow} !== 3'b010) begin
      n_fail++; $display("FAIL rst_flags we/busy/ovf got=%b exp=010", {bus.we, bus.busy, bus.overflow});
    end
    n_run++;
    if ({bus.top_row, bus.cur_row, bus.cur_col} !== '0) begin
      n_fail++; $display("FAIL rst_cursor got top=%0d row=%0d col=%0d exp 0", bus.top_row, bus.cur_row, bus.cur_col);
    end
    @(posedge sys_clk); #1;
    rst = 1'b0; bus.new_key = 1'b0;
    model_reset();
    while (n < 3000) begin
      @(negedge sys_clk);
      if (!bus.busy) break;
      n++;
    end
    n_run++;
    if (n != ROWS*COLS) begin n_fail++; $display("FAIL rst_busy_cycles got=%0d exp=%0d", n, ROWS*COLS); end
    wait_quiet("rst");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL rst_clear_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL rst_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_bs_home();
    send_key(8'h08, 8'h00); model_key(8'h08, 8'h00);
    wait_quiet("bs_home");
    n_run++;
    if (bus.cur_row !== 5'd0 || bus.cur_col !== 7'd0) begin
      n_fail++; $display("FAIL bs_home_cursor got r%0d c%0d exp r0 c0", bus.cur_row, bus.cur_col);
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL bs_home_write got=%0d writes exp=0", got_q.size() - rd); rd = got_q.size(); end
  endtask

  task automatic test_first_char();
    send_key(8'h41, 8'h1F); model_key(8'h41, 8'h1F);
    @(negedge sys_clk);
    n_run++;
    if ({bus.we, 16'(bus.mem_addr), bus.mem_data} !== {1'b1, 16'd0, 16'h1F41}) begin
      n_fail++; $display("FAIL first_char_latency got we=%b addr=%0d data=%h exp we=1 addr=0 data=1f41",
                         bus.we, bus.mem_addr, bus.mem_data);
    end
    wait_quiet("first_char");
    n_run++;
    if (bus.cur_col !== 7'd1 || bus.cur_row !== 5'd0) begin
      n_fail++; $display("FAIL first_char_cursor got r%0d c%0d exp r0 c1", bus.cur_row, bus.cur_col);
    end
    rd = rd + 1;  // the 'A' write was checked directly above
    exp_q.delete();
  endtask

  task automatic test_wrap_and_bs();
    logic [7:0] ch, at;
    send_key(8'h08, 8'h00); model_key(8'h08, 8'h00); wait_quiet("wrap_bs0");
    for (int i = 0; i < COLS; i++) begin
      ch = 8'($urandom_range(32, 126)); at = 8'($urandom);
      send_key(ch, at); model_key(ch, at); wait_quiet("wrap_fill");
    end
    send_key(8'h42, 8'h07); model_key(8'h42, 8'h07); wait_quiet("wrap_b");
    n_run++;
    if (bus.cur_row !== 5'd1 || bus.cur_col !== 7'd1) begin
      n_fail++; $display("FAIL wrap_cursor got r%0d c%0d exp r1 c1", bus.cur_row, bus.cur_col);
    end
    n_run++;
    if (got_q[got_q.size()-1] !== 32'h0050_0742) begin
      n_fail++; $display("FAIL wrap_b_write got=%h exp=00500742", got_q[got_q.size()-1]);
    end
    repeat (2) begin send_key(8'h08, 8'h00); model_key(8'h08, 8'h00); wait_quiet("wrap_bs"); end
    n_run++;
    if (bus.cur_row !== 5'd0 || bus.cur_col !== 7'd79) begin
      n_fail++; $display("FAIL bs_prev_row_cursor got r%0d c%0d exp r0 c79", bus.cur_row, bus.cur_col);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL wrap_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL wrap_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_scroll();
    int n = 0;
    for (int i = 0; i < ROWS-1; i++) begin
      send_key(8'h0D, 8'h00); model_key(8'h0D, 8'h00); wait_quiet("scroll_cr");
    end
    send_key(8'h0D, 8'h00); model_key(8'h0D, 8'h00);
    while (n < 200) begin
      @(negedge sys_clk);
      if (!bus.busy) break;
      n++;
    end
    n_run++;
    if (n != COLS) begin n_fail++; $display("FAIL scroll_busy_cycles got=%0d exp=%0d", n, COLS); end
    wait_quiet("scroll");
    n_run++;
    if (bus.top_row !== 5'd1 || bus.cur_row !== 5'd29 || bus.cur_col !== 7'd0) begin
      n_fail++; $display("FAIL scroll_cursor got top%0d r%0d c%0d exp top1 r29 c0", bus.top_row, bus.cur_row, bus.cur_col);
    end
    send_key(8'h43, 8'h07); model_key(8'h43, 8'h07); wait_quiet("scroll_c");
    n_run++;
    if (got_q[got_q.size()-1] !== 32'h0000_0743) begin
      n_fail++; $display("FAIL scroll_c_write got=%h exp=00000743", got_q[got_q.size()-1]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL scroll_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL scroll_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_pend_refill();
    int n = 0;
    send_key(8'h0D, 8'h00); model_key(8'h0D, 8'h00);
    repeat (5) @(posedge sys_clk);
    send_key(8'h78, 8'h2E); model_key(8'h78, 8'h2E);
    while (n < 200) begin
      @(negedge sys_clk);
      if (!bus.busy) break;
      n++;
    end
    // key lands in the cycle the slot drains
    bus.new_key = 1'b1; bus.ascii = 8'h79; bus.attr_in = 8'h4F;
    @(posedge sys_clk); #1;
    bus.new_key = 1'b0;
    model_key(8'h79, 8'h4F);
    wait_quiet("pend");
    n_run++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL pend_refill_overflow got=%b exp=0", bus.overflow); end
    n_run++;
    if (bus.cur_row !== 5'(m_row) || bus.cur_col !== 7'(m_col)) begin
      n_fail++; $display("FAIL pend_cursor got r%0d c%0d exp r%0d c%0d", bus.cur_row, bus.cur_col, m_row, m_col);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL pend_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL pend_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_overflow();
    send_key(8'h0D, 8'h00); model_key(8'h0D, 8'h00);
    repeat (4) @(posedge sys_clk); #1;
    bus.new_key = 1'b1; bus.ascii = 8'h70; bus.attr_in = 8'h1E;
    @(posedge sys_clk); #1; bus.ascii = 8'h71;
    @(posedge sys_clk); #1; bus.ascii = 8'h72;
    @(posedge sys_clk); #1; bus.new_key = 1'b0;
    model_key(8'h70, 8'h1E);
    @(negedge sys_clk);
    n_run++;
    if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got=%b exp=1", bus.overflow); end
    wait_quiet("ovf");
    n_run++;
    if (bus.overflow !== 1'b1 || bus.cur_col !== 7'(m_col)) begin
      n_fail++; $display("FAIL overflow_sticky got ovf=%b c%0d exp ovf=1 c%0d", bus.overflow, bus.cur_col, m_col);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL ovf_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL ovf_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_random();
    logic [7:0] ch, at;
    int k;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      ch = 8'($urandom_range(32, 126));
      else if (k == 6) ch = 8'h0D;
      else if (k == 7) ch = 8'h08;
      else if (k == 8) ch = 8'h09;
      else             ch = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(127, 255));
      at = 8'($urandom);
      send_key(ch, at); model_key(ch, at); wait_quiet("rand");
      n_run++;
      if (bus.cur_row !== 5'(m_row) || bus.cur_col !== 7'(m_col) || bus.top_row !== 5'(m_top)) begin
        n_fail++; $display("FAIL rand_cursor key=%h got top%0d r%0d c%0d exp top%0d r%0d c%0d",
                           ch, bus.top_row, bus.cur_row, bus.cur_col, m_top, m_row, m_col);
      end
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL rand_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL rand_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  task automatic test_reset_mid_clr();
    int n = 0;
    for (int i = 0; i < ROWS && m_row != ROWS-1; i++) begin
      send_key(8'h0D, 8'h00); model_key(8'h0D, 8'h00); wait_quiet("mid_cr");
    end
    send_key(8'h0D, 8'h00);
    repeat (10) @(posedge sys_clk); #1;
    rst = 1'b1; bus.new_key = 1'b1; bus.ascii = 8'h41;
    @(negedge sys_clk);
    n_run++;
    if (bus.we !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_flags got we=%b busy=%b exp we=0 busy=1", bus.we, bus.busy);
    end
    @(negedge sys_clk);
    n_run++;
    if ({bus.top_row, bus.cur_row, bus.cur_col, bus.overflow} !== '0) begin
      n_fail++; $display("FAIL mid_rst_state got top%0d r%0d c%0d ovf=%b exp all 0",
                         bus.top_row, bus.cur_row, bus.cur_col, bus.overflow);
    end
    rd = got_q.size();
    @(posedge sys_clk); #1;
    rst = 1'b0; bus.new_key = 1'b0;
    model_reset();
    while (n < 3000) begin
      @(negedge sys_clk);
      if (!bus.busy) break;
      n++;
    end
    n_run++;
    if (n != ROWS*COLS) begin n_fail++; $display("FAIL mid_rst_busy_cycles got=%0d exp=%0d", n, ROWS*COLS); end
    wait_quiet("mid_rst");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_run++;
      g = (rd < got_q.size()) ? got_q[rd] : 32'hxxxxxxxx; rd++;
      if (g !== e) begin n_fail++; $display("FAIL mid_rst_write got=%h exp=%h", g, e); end
    end
    n_run++;
    if (rd != got_q.size()) begin n_fail++; $display("FAIL mid_rst_extra_writes got=%0d exp=%0d", got_q.size(), rd); rd = got_q.size(); end
  endtask

  initial begin
    bus.new_key = 1'b0; bus.ascii = 8'h00; bus.attr_in = 8'h00;
    rd = 0;
    test_reset();
    test_bs_home();
    test_first_char();
    test_wrap_and_bs();
    test_scroll();
    test_pend_refill();
    test_overflow();
    test_random();
    test_reset_mid_clr();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 80: characters per row.
REQ-002 Parameter ROWS, default 30: rows in the character buffer.
REQ-003 Parameter ADDR_W, default 12: buffer address width; ROWS*COLS SHALL be at most 2^ADDR_W.
REQ-004 Parameter DEF_ATTR, default 8'h07: attribute byte written by screen and line clears.
REQ-005 sys_clk  in  1  single clock for all logic.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 new_key  in  1  one-cycle pulse; ascii is valid in the same cycle.
REQ-008 ascii  in  8  key code from the keyboard driver.
REQ-009 attr_in  in  8  attribute byte for printable characters, sampled at key accept.
REQ-010 mem_addr  out  ADDR_W  character buffer write address.
REQ-011 mem_data  out  16  write data {attr[15:8], char[7:0]}.
REQ-012 we  out  1  write strobe, one cycle per buffer cell.
REQ-013 top_row  out  $clog2(ROWS)  physical row shown at the top of the screen; used by the video driver as the scroll offset.
REQ-014 cur_col / cur_row  out  $clog2(COLS) / $clog2(ROWS)  logical cursor position, relative to top_row.
REQ-015 busy  out  1  high while a screen clear or line clear is in progress.
REQ-016 overflow  out  1  sticky flag: a key was dropped; cleared only by rst.

Function
REQ-017 Physical address SHALL be ((top_row+cur_row) mod ROWS)*COLS + cur_col, computed from a row-base register with no multiplier.
REQ-018 States: CLR_ALL, IDLE, WRITE, CLR_LINE.
REQ-019 CLR_ALL SHALL write {DEF_ATTR,8'h20} to addresses 0..ROWS*COLS-1 at one per cycle, with busy=1, then go to IDLE.
REQ-020 Key accept SHALL happen in IDLE when new_key=1 or the pending slot is full; the pending slot takes priority.
REQ-021 Printable code 0x20-0x7E: the next cycle SHALL be WRITE with we=1, data {attr,ascii} at the cursor; the cursor then advances one column.
REQ-022 Advance from cur_col=COLS-1 SHALL wrap to column 0 of the next row.
REQ-023 0x0D (CR) SHALL move the cursor to column 0 of the next row, with no write.
REQ-024 0x08 (BS) SHALL move the cursor back one cell and write {DEF_ATTR,8'h20} there.
  - At col 0 with row>0: go to col COLS-1 of the previous row.
  - At row 0, col 0: no move, no write.
REQ-025 0x09 (TAB) SHALL move the cursor to the next column that is a multiple of 8, clamped to COLS-1, with no write.
REQ-026 Any other code SHALL be ignored, with no write and no cursor change.
REQ-027 Row advance from cur_row<ROWS-1 SHALL increment cur_row only.
REQ-028 Row advance from cur_row=ROWS-1 SHALL do all of the following:
  - increment top_row modulo ROWS;
  - keep cur_row at ROWS-1;
  - enter CLR_LINE, writing {DEF_ATTR,8'h20} to all COLS cells of the new bottom physical row, busy=1, COLS cycles;
  - return to IDLE.
REQ-029 A key arriving while busy or not in IDLE SHALL be stored in a one-entry pending slot (ascii plus attr_in).
REQ-030 A key arriving while the pending slot is full SHALL be dropped and SHALL set overflow.
REQ-031 A key arriving in the same cycle the pending slot is consumed SHALL be stored into the slot, not dropped.
REQ-032 we SHALL be 0 in IDLE; mem_addr and mem_data are don't-care whenever we=0.
REQ-033 Key-accept-to-we latency SHALL be exactly 1 cycle.

Reset
REQ-034 While rst=1, all of these SHALL hold: we=0, busy=1, top_row=0, cur_col=0, cur_row=0, overflow=0, pending slot empty, state=CLR_ALL with its counter at 0.
REQ-035 Asserting rst in any state, including mid-CLR_LINE, SHALL abort that operation and restart CLR_ALL from address 0 on the first cycle after rst falls.
REQ-036 Keys presented during rst SHALL be ignored.

Verification (COLS=80, ROWS=30 unless stated)
REQ-037 Reset release: busy=1 for 2400 cycles; we writes 0x0720 to addresses 0..2399 in order; then busy=0.
REQ-038 After init, 'A' (0x41) with attr_in=0x1F: one cycle later we=1, addr=0, data=0x1F41; then cur_col=1.
REQ-039 80 printable keys, then 'B': 'B' is written at addr 80; cursor ends at row 1, col 1.
REQ-040 With the cursor at row 29, CR: top_row=1, busy=1 for 80 cycles writing 0x0720 to addrs 0..79; cursor at row 29, col 0. A following 'C' is written to addr 0.
REQ-041 Three keys during CLR_LINE: the first is pended and written after busy falls; the second is stored once the slot frees, otherwise dropped; overflow=1 after any drop.
REQ-042 BS at row 0, col 0: no we, cursor unchanged. BS at row 1, col 0: writes 0x0720 at addr 79; cursor at row 0, col 79.
